nano4k_flash_sequencer: RTL and testbench

- Command sequencer between user logic and the nano4k_spi_flash byte interface; runs on the interface clock domain.
- Runs the power-up software-reset sequence (RSTEN, RST, settle), then serves single-byte READ, PROGRAM and SECTOR ERASE requests.
- PROGRAM and ERASE are expanded into WREN, the command, and RDSR polling until WIP clears.
- Returns one response per request: data, or an error flag.

---
 rtl/nano4k_flash_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_nano4k_flash_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nano4k_flash_sequencer.sv
// nano4k_flash_sequencer: power-up soft reset, then READ / PROGRAM / SECTOR_ERASE
// Ports: interfaceClk/reset; req_*/rsp_*/init_done user side; interfaceEnable_n/f*/strobes flash side.
module nano4k_flash_sequencer #(
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned RST_WAIT_CYCLES = 300,
  parameter int unsigned XFER_TIMEOUT    = 1024,
  parameter int unsigned POLL_MAX        = 65535
) (
  input  logic        interfaceClk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [21:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        init_done,
  output logic        interfaceEnable_n,
  output logic [7:0]  fCommand,
  output logic [21:0] fAddress,
  output logic [7:0]  fData_WR,
  input  logic [7:0]  fData_RD,
  input  logic        RdDataValid,
  input  logic        WrDataReady
);

  localparam logic [7:0] OPC_RSTEN = 8'h66;
  localparam logic [7:0] OPC_RST   = 8'h99;
  localparam logic [7:0] OPC_WREN  = 8'h06;
  localparam logic [7:0] OPC_PP    = 8'h02;
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_RDSR  = 8'h05;
  localparam logic [7:0] OPC_SE    = 8'h20;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_SE   = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT_RSTEN,
    S_INIT_RST,
    S_INIT_WAIT,
    S_IDLE,
    S_WREN,
    S_CMD,
    S_POLL,
    S_RESP
  } state_t;

  // Sub-phases of one flash transaction in any issuing state.
  typedef enum logic [1:0] {
    P_SETUP,
    P_ARM,
    P_XFER,
    P_GAP
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] poll_q, poll_d;
  logic        tmo_q, tmo_d;
  logic [1:0]  op_q, op_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd_q, rd_d;
  logic        en_n_q, en_n_d;
  logic [7:0]  fcmd_q, fcmd_d;
  logic [21:0] faddr_q, faddr_d;
  logic [7:0]  fdata_q, fdata_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        init_done_q, init_done_d;

  logic [7:0]  cmd_sel;
  logic [21:0] addr_sel;
  logic [7:0]  data_sel;
  logic        rd_cmd;
  logic        strobe;
  logic        in_init;
  logic [31:0] cnt_inc;
  logic [31:0] poll_inc;

  // Read-type opcodes complete on RdDataValid, everything else on
  // WrDataReady; both at once still counts as one completion.
  assign rd_cmd = (fcmd_q == OPC_READ) || (fcmd_q == OPC_RDSR);
  assign strobe = rd_cmd ? RdDataValid : WrDataReady;

  always_comb begin
    cmd_sel  = OPC_RDSR;
    addr_sel = '0;
    data_sel = '0;
    unique case (state_q)
      S_INIT_RSTEN: cmd_sel = OPC_RSTEN;
      S_INIT_RST:   cmd_sel = OPC_RST;
      S_WREN:       cmd_sel = OPC_WREN;
      S_CMD: begin
        unique case (1'b1)
          op_q == OP_READ: begin
            cmd_sel  = OPC_READ;
            addr_sel = addr_q;
          end
          op_q == OP_PROG: begin
            cmd_sel  = OPC_PP;
            addr_sel = addr_q;
            data_sel = wdata_q;
          end
          default: begin
            cmd_sel  = OPC_SE;
            addr_sel = {addr_q[21:12], 12'h000};
          end
        endcase
      end
      default: cmd_sel = OPC_RDSR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    tmo_d       = tmo_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    en_n_d      = en_n_q;
    fcmd_d      = fcmd_q;
    faddr_d     = faddr_q;
    fdata_d     = fdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    init_done_d = init_done_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    poll_inc    = (poll_q == '1) ? poll_q : poll_q + 32'd1;
    in_init     = (state_q == S_INIT_RSTEN) ||
                  (state_q == S_INIT_RST);

    unique case (state_q)
      S_INIT_WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_q >= RST_WAIT_CYCLES - 1) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end

      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          poll_d  = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          phase_d = P_SETUP;
          unique case (req_op)
            OP_READ: state_d = S_CMD;
            OP_PROG: state_d = S_WREN;
            OP_SE:   state_d = S_WREN;
            OP_ILL: begin
              state_d     = S_RESP;
              rsp_error_d = 1'b1;
              rsp_rdata_d = '0;
            end
          endcase
        end
      end

      S_RESP: state_d = S_IDLE;

      default: begin
        unique case (phase_q)
          P_SETUP: begin
            fcmd_d  = cmd_sel;
            faddr_d = addr_sel;
            fdata_d = data_sel;
            phase_d = P_ARM;
          end

          P_ARM: begin
            en_n_d  = 1'b0;
            cnt_d   = '0;
            phase_d = P_XFER;
          end

          P_XFER: begin
            cnt_d = cnt_inc;
            if (strobe || cnt_q >= XFER_TIMEOUT - 1) begin
              en_n_d = 1'b1;
              cnt_d  = '0;
              tmo_d  = !strobe;
              if (strobe && rd_cmd)
                rd_d = fData_RD;
              // The settle wait counts from the RST enable rise.
              if (strobe && state_q == S_INIT_RST)
                state_d = S_INIT_WAIT;
              else
                phase_d = P_GAP;
            end
          end

          P_GAP: begin
            cnt_d = cnt_inc;
            if (cnt_q >= GAP_CYCLES - 1) begin
              cnt_d   = '0;
              tmo_d   = 1'b0;
              phase_d = P_SETUP;
              if (tmo_q) begin
                if (in_init) begin
                  state_d = S_INIT_RSTEN;
                end else begin
                  state_d     = S_RESP;
                  rsp_error_d = 1'b1;
                  rsp_rdata_d = '0;
                end
              end else begin
                unique case (state_q)
                  S_INIT_RSTEN: state_d = S_INIT_RST;
                  S_INIT_RST:   state_d = S_INIT_WAIT;
                  S_WREN:       state_d = S_CMD;
                  S_CMD: begin
                    if (op_q == OP_READ) begin
                      state_d     = S_RESP;
                      rsp_error_d = 1'b0;
                      rsp_rdata_d = rd_q;
                    end else begin
                      state_d = S_POLL;
                    end
                  end
                  S_POLL: begin
                    if (!rd_q[0]) begin
                      state_d     = S_RESP;
                      rsp_error_d = 1'b0;
                      rsp_rdata_d = '0;
                    end else if (poll_q >= POLL_MAX - 1) begin
                      state_d     = S_RESP;
                      rsp_error_d = 1'b1;
                      rsp_rdata_d = '0;
                    end else begin
                      poll_d = poll_inc;
                    end
                  end
                  default: state_d = state_q;
                endcase
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge interfaceClk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT_RSTEN;
      phase_q     <= P_SETUP;
      cnt_q       <= '0;
      poll_q      <= '0;
      tmo_q       <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      en_n_q      <= 1'b1;
      fcmd_q      <= '0;
      faddr_q     <= '0;
      fdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      tmo_q       <= tmo_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      en_n_q      <= en_n_d;
      fcmd_q      <= fcmd_d;
      faddr_q     <= faddr_d;
      fdata_q     <= fdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE) && init_done_q;
  assign rsp_valid         = (state_q == S_RESP);
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_error         = rsp_error_q;
  assign init_done         = init_done_q;
  assign interfaceEnable_n = en_n_q;
  assign fCommand          = fcmd_q;
  assign fAddress          = faddr_q;
  assign fData_WR          = fdata_q;

endmodule

// File: tb/tb_nano4k_flash_sequencer.sv
// tb_nano4k_flash_sequencer: random requests against a behavioural flash
// model and a transaction-level reference of the expected command stream.
module tb_nano4k_flash_sequencer;

  localparam int GAP  = 4;
  localparam int RSTW = 300;
  localparam int TMO  = 1024;
  localparam int PMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [21:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        init_done;
  logic        interfaceEnable_n;
  logic [7:0]  fCommand;
  logic [21:0] fAddress;
  logic [7:0]  fData_WR;
  logic [7:0]  fData_RD;
  logic        RdDataValid;
  logic        WrDataReady;

  always #5 clk = ~clk;

  nano4k_flash_sequencer #(
    .GAP_CYCLES(GAP),
    .RST_WAIT_CYCLES(RSTW),
    .XFER_TIMEOUT(TMO),
    .POLL_MAX(PMAX)
  ) dut (
    .interfaceClk(clk),
    .reset(rst_n),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .init_done(init_done),
    .interfaceEnable_n(interfaceEnable_n),
    .fCommand(fCommand),
    .fAddress(fAddress),
    .fData_WR(fData_WR),
    .fData_RD(fData_RD),
    .RdDataValid(RdDataValid),
    .WrDataReady(WrDataReady)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [21:0] addr;
    logic [7:0]  data;
    int          len;
  } txn_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  txn_t txq[$];
  txn_t exq[$];
  rsp_t rsq[$];

  int checks = 0;
  int errors = 0;

  int nedge = 0;
  int en_rise_at = 0;
  int init_at = 0;
  int gap_viol = 0;
  int hold_viol = 0;
  int setup_viol = 0;

  logic [7:0] mem [0:8191];
  int         busy_cfg = 0;
  int         busy_left = 0;
  logic [7:0] hang_cmd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Bus monitor: records every enable-low window as one transaction.
  initial begin
    txn_t       cur;
    rsp_t       r;
    logic       in_txn = 1'b0;
    logic       init_prev = 1'b0;
    int         hi_run = 1000;
    logic [7:0] pc = '0;
    logic [21:0] pa = '0;
    logic [7:0] pd = '0;
    cur = '{8'h00, 22'h0, 8'h00, 0};
    forever begin
      @(negedge clk);
      nedge++;
      if (interfaceEnable_n === 1'b0) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cur = '{fCommand, fAddress, fData_WR, 0};
          if (hi_run < GAP) gap_viol++;
          if (fCommand !== pc || fAddress !== pa || fData_WR !== pd)
            setup_viol++;
        end else if (fCommand !== cur.cmd || fAddress !== cur.addr ||
                     fData_WR !== cur.data) begin
          hold_viol++;
        end
        cur.len++;
        hi_run = 0;
      end else begin
        if (in_txn) begin
          txq.push_back(cur);
          in_txn = 1'b0;
          en_rise_at = nedge;
        end
        hi_run++;
      end
      if (rsp_valid === 1'b1) begin
        r.rdata = rsp_rdata;
        r.err   = rsp_error;
        rsq.push_back(r);
      end
      if (init_done === 1'b1 && !init_prev) init_at = nedge;
      init_prev = (init_done === 1'b1);
      pc = fCommand;
      pa = fAddress;
      pd = fData_WR;
    end
  end

  // Flash model: random latency, stray strobes while idle, WIP countdown.
  initial begin
    int   lat;
    int   lat_cnt;
    logic done;
    logic both;
    RdDataValid = 1'b0;
    WrDataReady = 1'b0;
    fData_RD    = '0;
    lat_cnt     = 0;
    done        = 1'b0;
    lat         = 1;
    foreach (mem[i]) mem[i] = 8'($urandom);
    forever begin
      @(negedge clk);
      RdDataValid = 1'b0;
      WrDataReady = 1'b0;
      if (interfaceEnable_n !== 1'b0) begin
        lat_cnt = 0;
        done    = 1'b0;
        lat     = $urandom_range(1, 6);
        if ($urandom_range(0, 7) == 0) begin
          RdDataValid = 1'b1;
          fData_RD    = 8'($urandom);
        end
        if ($urandom_range(0, 7) == 0) WrDataReady = 1'b1;
      end else if (!done) begin
        lat_cnt++;
        if (lat_cnt >= lat && fCommand != hang_cmd) begin
          done = 1'b1;
          both = ($urandom_range(0, 3) == 0);
          case (fCommand)
            8'h03: begin
              fData_RD    = mem[fAddress[12:0]];
              RdDataValid = 1'b1;
            end
            8'h05: begin
              fData_RD    = {7'($urandom), busy_left != 0};
              if (busy_left > 0) busy_left--;
              RdDataValid = 1'b1;
            end
            8'h02: begin
              mem[fAddress[12:0]] = fData_WR;
              busy_left   = busy_cfg;
              WrDataReady = 1'b1;
            end
            8'h20: begin
              for (int i = 0; i < 4096; i++)
                mem[{fAddress[12], 12'(i)}] = 8'hFF;
              busy_left   = busy_cfg;
              WrDataReady = 1'b1;
            end
            default: WrDataReady = 1'b1;
          endcase
          if (both) begin
            RdDataValid = 1'b1;
            WrDataReady = 1'b1;
          end
        end
      end
    end
  end

  function automatic void push_exp(input logic [7:0] c,
                                   input logic [21:0] a,
                                   input logic [7:0] d);
    txn_t t;
    t.cmd  = c;
    t.addr = a;
    t.data = d;
    t.len  = 0;
    exq.push_back(t);
  endfunction

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    tick();
    chk({tag, "_to"}, n < 3000, 1);
    chk({tag, "_ntx"}, txq.size(), 2);
    if (txq.size() == 2) begin
      chk({tag, "_cmd0"}, txq[0].cmd, 8'h66);
      chk({tag, "_cmd1"}, txq[1].cmd, 8'h99);
    end
    chk({tag, "_dly"}, init_at - en_rise_at, RSTW);
    chk({tag, "_rdy"}, req_ready, 1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [21:0] addr,
                        input logic [7:0] wd, input int busy,
                        input logic hang);
    int         n;
    int         nrd;
    logic [7:0] exp_rd;
    logic       exp_err;
    exq.delete();
    exp_rd  = '0;
    exp_err = 1'b0;
    nrd = (busy < PMAX) ? busy + 1 : PMAX;
    case (op)
      2'b00: begin
        push_exp(8'h03, addr, 8'h00);
        if (hang) exp_err = 1'b1;
        else exp_rd = mem[addr[12:0]];
      end
      2'b01: begin
        push_exp(8'h06, 22'h0, 8'h00);
        push_exp(8'h02, addr, wd);
        repeat (nrd) push_exp(8'h05, 22'h0, 8'h00);
        exp_err = (busy >= PMAX);
      end
      2'b10: begin
        push_exp(8'h06, 22'h0, 8'h00);
        push_exp(8'h20, {addr[21:12], 12'h000}, 8'h00);
        repeat (nrd) push_exp(8'h05, 22'h0, 8'h00);
        exp_err = (busy >= PMAX);
      end
      default: exp_err = 1'b1;
    endcase
    busy_cfg = busy;
    hang_cmd = hang ? 8'h03 : 8'h00;
    txq.delete();
    rsq.delete();
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 22'($urandom);
    req_wdata = 8'($urandom);
    chk("acc_to", n < 4000, 1);
    chk("rdy_drop", req_ready, 0);
    n = 0;
    while (rsq.size() == 0 && n < 4000) begin
      tick();
      n++;
    end
    repeat (8) tick();
    chk("rsp_to", n < 4000, 1);
    chk("rsp_cnt", rsq.size(), 1);
    if (rsq.size() > 0) begin
      chk("rsp_err", rsq[0].err, exp_err);
      chk("rsp_rd", rsq[0].rdata, exp_rd);
    end
    chk("ntx", txq.size(), exq.size());
    foreach (exq[i]) begin
      if (i < txq.size()) begin
        chk("cmd", txq[i].cmd, exq[i].cmd);
        if (exq[i].cmd inside {8'h03, 8'h02, 8'h20})
          chk("addr", txq[i].addr, exq[i].addr);
        if (exq[i].cmd == 8'h02)
          chk("wdata", txq[i].data, exq[i].data);
      end
    end
    if (hang && txq.size() > 0) chk("tmo_len", txq[0].len, TMO);
    hang_cmd = 8'h00;
  endtask

  initial begin
    int n;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_en", interfaceEnable_n, 1);
    chk("rst_cmd", fCommand, 0);
    chk("rst_addr", fAddress, 0);
    chk("rst_wd", fData_WR, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rd", rsp_rdata, 0);
    chk("rst_re", rsp_error, 0);
    chk("rst_init", init_done, 0);
    txq.delete();
    rst_n = 1'b1;
    wait_init("init");

    mem[13'h0A0] = 8'h5A;
    do_req(2'b00, 22'h0000A0, 8'h00, 0, 1'b0);
    do_req(2'b01, 22'h0000A0, 8'h37, 2, 1'b0);
    do_req(2'b10, 22'h012345, 8'h00, 20, 1'b0);
    do_req(2'b00, 22'h000123, 8'h00, 0, 1'b1);
    do_req(2'b11, 22'h000010, 8'h00, 0, 1'b0);
    do_req(2'b00, 22'h0000A0, 8'h00, 0, 1'b0);

    // Reset while a PP transaction is in flight.
    hang_cmd  = 8'h02;
    busy_cfg  = 0;
    req_op    = 2'b01;
    req_addr  = 22'h000055;
    req_wdata = 8'hC3;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!(interfaceEnable_n === 1'b0 && fCommand == 8'h02) &&
           n < 2000) begin
      tick();
      n++;
    end
    chk("pp_seen", n < 2000, 1);
    repeat (5) tick();
    rsq.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", interfaceEnable_n, 1);
    chk("mid_rst_init", init_done, 0);
    repeat (3) tick();
    hang_cmd = 8'h00;
    txq.delete();
    rst_n = 1'b1;
    wait_init("reinit");
    chk("mid_rst_norsp", rsq.size(), 0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [21:0] a;
      int          b;
      logic        h;
      op = 2'($urandom_range(0, 3));
      a  = 22'($urandom) & 22'h3F100F;
      b  = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 10)
                                       : $urandom_range(0, 3);
      h  = (op == 2'b00) && ($urandom_range(0, 9) == 0);
      do_req(op, a, 8'($urandom), b, h);
    end

    chk("gap_viol", gap_viol, 0);
    chk("hold_viol", hold_viol, 0);
    chk("setup_viol", setup_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
